// File: rtl/mem_bus_pkg.sv
// Shared definitions for the byte-wide 4-phase handshake memory bus.
// Used by the responder, the core-side bus master and the bench BFM.
package mem_bus_pkg;

  // Default depth of the synchroniser chains on the async strobes.
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Which byte of a transfer is currently on the bus.
  typedef enum logic [1:0] {
    PH_ADDR_LO = 2'd0,
    PH_ADDR_HI = 2'd1,
    PH_DATA    = 2'd2
  } phase_e;

  // Responder state machine encoding.
  typedef enum logic [3:0] {
    ST_AL     = 4'd0,
    ST_AL_REL = 4'd1,
    ST_AH     = 4'd2,
    ST_AH_REL = 4'd3,
    ST_D      = 4'd4,
    ST_RD_MEM = 4'd5,
    ST_DRIVE  = 4'd6,
    ST_WR_MEM = 4'd7,
    ST_D_REL  = 4'd8
  } state_e;

  // Map a responder state onto the bus phase it belongs to.
  function automatic phase_e state_phase(input state_e s);
    phase_e p;
    case (s)
      ST_AL, ST_AL_REL: p = PH_ADDR_LO;
      ST_AH, ST_AH_REL: p = PH_ADDR_HI;
      default:          p = PH_DATA;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mem_bus_responder_bus_sync.sv
// Multi-flop synchroniser for one asynchronous bus strobe.
// Clears to 0 on reset so a strobe is never seen active out of reset.
module bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {STAGES{1'b0}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the byte-wide 4-phase handshake bus.
// Collects addr lo / addr hi / data bytes, runs one access on the local
// SRAM port and returns read data on the shared bus. Every byte is acked,
// and a byte is only acked once the previous strobe has been seen low.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int RD_PREFETCH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  output logic        bus_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic        proto_err
);

  // Chains shorter than two flops are not safe against metastability.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic PREFETCH_EN = (RD_PREFETCH != 0) ? 1'b1 : 1'b0;

  // Synchronised strobes.
  logic w_req;
  logic w_rd;
  logic w_wr;

  // State and registered outputs.
  state_e      r_state;
  logic        r_ack;
  logic        r_oe;
  logic [7:0]  r_bus_out;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [7:0]  r_addr_lo;
  logic [7:0]  r_addr_hi;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata_q;
  logic        r_prefetched;  // r_rdata_q holds data for the pending data phase
  logic        r_rd_direct;   // read issued from the data phase: drive straight after rvalid
  logic        r_gnt_seen;    // current SRAM read has been granted, rvalid may follow
  logic        r_proto_err;

  // Next-state values.
  state_e      w_state_nxt;
  logic        w_ack_nxt;
  logic        w_oe_nxt;
  logic [7:0]  w_bus_out_nxt;
  logic        w_mem_req_nxt;
  logic        w_mem_we_nxt;
  logic [7:0]  w_addr_lo_nxt;
  logic [7:0]  w_addr_hi_nxt;
  logic [7:0]  w_wdata_nxt;
  logic [7:0]  w_rdata_q_nxt;
  logic        w_prefetched_nxt;
  logic        w_rd_direct_nxt;
  logic        w_gnt_seen_nxt;
  logic        w_proto_err_nxt;
  logic        w_idle_flags;

  bus_sync #(.STAGES(SYNC_N)) u_sync_req (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus_req),
    .q     (w_req)
  );

  bus_sync #(.STAGES(SYNC_N)) u_sync_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus_rd),
    .q     (w_rd)
  );

  bus_sync #(.STAGES(SYNC_N)) u_sync_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus_wr),
    .q     (w_wr)
  );

  // Initiator has dropped both cycle flags: the transfer is abandoned.
  assign w_idle_flags = ~w_rd & ~w_wr;

  // Next-state and next-output decode for the byte handshake.
  always_comb begin
    w_state_nxt      = r_state;
    w_ack_nxt        = r_ack;
    w_oe_nxt         = r_oe;
    w_bus_out_nxt    = r_bus_out;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_addr_lo_nxt    = r_addr_lo;
    w_addr_hi_nxt    = r_addr_hi;
    w_wdata_nxt      = r_wdata;
    w_rdata_q_nxt    = r_rdata_q;
    w_prefetched_nxt = r_prefetched;
    w_rd_direct_nxt  = r_rd_direct;
    w_gnt_seen_nxt   = r_gnt_seen;
    // rd and wr together is a protocol violation; it latches until reset.
    w_proto_err_nxt  = r_proto_err | (w_rd & w_wr);

    case (r_state)
      ST_AL: begin
        if (w_idle_flags && !r_ack) begin
          w_prefetched_nxt = 1'b0;
        end else if (w_req) begin
          w_addr_lo_nxt = bus_in;
          w_ack_nxt     = 1'b1;
          w_state_nxt   = ST_AL_REL;
        end else begin
          w_state_nxt = ST_AL;
        end
      end

      ST_AL_REL: begin
        if (!w_req) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = ST_AH;
        end else begin
          w_state_nxt = ST_AL_REL;
        end
      end

      ST_AH: begin
        if (w_idle_flags && !r_ack) begin
          w_prefetched_nxt = 1'b0;
          w_state_nxt      = ST_AL;
        end else if (w_req) begin
          w_addr_hi_nxt = bus_in;
          w_ack_nxt     = 1'b1;
          w_state_nxt   = ST_AH_REL;
        end else begin
          w_state_nxt = ST_AH;
        end
      end

      ST_AH_REL: begin
        if (!w_req) begin
          w_ack_nxt = 1'b0;
          if (w_rd && PREFETCH_EN) begin
            // Address is complete: start the SRAM read now to hide its latency.
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = 1'b0;
            w_rd_direct_nxt = 1'b0;
            w_gnt_seen_nxt  = 1'b0;
            w_state_nxt     = ST_RD_MEM;
          end else begin
            w_state_nxt = ST_D;
          end
        end else begin
          w_state_nxt = ST_AH_REL;
        end
      end

      ST_D: begin
        if (w_idle_flags && !r_ack) begin
          w_prefetched_nxt = 1'b0;
          w_state_nxt      = ST_AL;
        end else if (w_req && w_rd) begin
          // A read takes priority even when wr is also (illegally) high.
          if (r_prefetched) begin
            w_bus_out_nxt = r_rdata_q;
            w_oe_nxt      = 1'b1;
            w_state_nxt   = ST_DRIVE;
          end else begin
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = 1'b0;
            w_rd_direct_nxt = 1'b1;
            w_gnt_seen_nxt  = 1'b0;
            w_state_nxt     = ST_RD_MEM;
          end
        end else if (w_req && w_wr) begin
          w_wdata_nxt   = bus_in;
          w_mem_req_nxt = 1'b1;
          w_mem_we_nxt  = 1'b1;
          w_state_nxt   = ST_WR_MEM;
        end else begin
          w_state_nxt = ST_D;
        end
      end

      ST_RD_MEM: begin
        if (r_mem_req && mem_gnt) begin
          w_mem_req_nxt  = 1'b0;
          w_gnt_seen_nxt = 1'b1;
        end else begin
          w_gnt_seen_nxt = r_gnt_seen;
        end
        // rvalid only counts once the request has been granted.
        if (r_gnt_seen && mem_rvalid) begin
          w_rdata_q_nxt  = mem_rdata;
          w_gnt_seen_nxt = 1'b0;
          if (r_rd_direct) begin
            w_bus_out_nxt = mem_rdata;
            w_oe_nxt      = 1'b1;
            w_state_nxt   = ST_DRIVE;
          end else begin
            w_prefetched_nxt = 1'b1;
            w_state_nxt      = ST_D;
          end
        end else begin
          w_state_nxt = ST_RD_MEM;
        end
      end

      ST_DRIVE: begin
        // Data has been on the bus for a cycle; now it is safe to ack.
        w_ack_nxt   = 1'b1;
        w_state_nxt = ST_D_REL;
      end

      ST_WR_MEM: begin
        if (mem_gnt) begin
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_ack_nxt     = 1'b1;
          w_state_nxt   = ST_D_REL;
        end else begin
          w_state_nxt = ST_WR_MEM;
        end
      end

      ST_D_REL: begin
        // Keep driving read data until the initiator has released req.
        if (!w_req) begin
          w_ack_nxt        = 1'b0;
          w_oe_nxt         = 1'b0;
          w_prefetched_nxt = 1'b0;
          w_state_nxt      = ST_AL;
        end else begin
          w_state_nxt = ST_D_REL;
        end
      end

      default: begin
        w_state_nxt      = ST_AL;
        w_ack_nxt        = 1'b0;
        w_oe_nxt         = 1'b0;
        w_mem_req_nxt    = 1'b0;
        w_mem_we_nxt     = 1'b0;
        w_prefetched_nxt = 1'b0;
        w_gnt_seen_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears ack/oe asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_AL;
      r_ack        <= 1'b0;
      r_oe         <= 1'b0;
      r_bus_out    <= 8'h00;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_addr_lo    <= 8'h00;
      r_addr_hi    <= 8'h00;
      r_wdata      <= 8'h00;
      r_rdata_q    <= 8'h00;
      r_prefetched <= 1'b0;
      r_rd_direct  <= 1'b0;
      r_gnt_seen   <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ack        <= w_ack_nxt;
      r_oe         <= w_oe_nxt;
      r_bus_out    <= w_bus_out_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_addr_lo    <= w_addr_lo_nxt;
      r_addr_hi    <= w_addr_hi_nxt;
      r_wdata      <= w_wdata_nxt;
      r_rdata_q    <= w_rdata_q_nxt;
      r_prefetched <= w_prefetched_nxt;
      r_rd_direct  <= w_rd_direct_nxt;
      r_gnt_seen   <= w_gnt_seen_nxt;
      r_proto_err  <= w_proto_err_nxt;
    end
  end

  assign bus_out   = r_bus_out;
  assign bus_oe    = r_oe;
  assign bus_ack   = r_ack;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = {r_addr_hi, r_addr_lo};
  assign mem_wdata = r_wdata;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: initiator BFM, SRAM model with scoreboard
// of expected SRAM operations and expected read bytes.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic [7:0]  bus_in = 8'h00;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        bus_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        proto_err;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } sram_op_t;

  sram_op_t   exp_ops[$];
  logic [7:0] exp_rd[$];
  logic [7:0] sram [0:65535];

  int n_checks = 0;
  int n_errors = 0;
  int gnt_dly = 2;
  int rd_dly = 3;
  int ack_cnt = 0;
  int memreq_rises = 0;
  logic prev_ack = 1'b0;
  logic prev_mreq = 1'b0;
  bit tb_rd_phase = 1'b0;

  mem_bus_responder #(
    .SYNC_STAGES (2),
    .RD_PREFETCH (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_req    (bus_req),
    .bus_rd     (bus_rd),
    .bus_wr     (bus_wr),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .bus_ack    (bus_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // SRAM model: grants after gnt_dly cycles, returns read data rd_dly cycles later.
  initial begin
    int gcnt;
    int rv_cnt;
    logic [7:0] rv_data;
    sram_op_t op;
    gcnt = 0;
    rv_cnt = -1;
    rv_data = 8'h00;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 8'h00;
    for (int i = 0; i < 65536; i++) sram[i] = 8'h00;
    sram[16'hBEEF] = 8'h5A;
    sram[16'h0000] = 8'h3C;
    sram[16'h0040] = 8'h99;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        gcnt = 0;
        rv_cnt = -1;
      end else begin
        if (rv_cnt > 0) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = rv_data;
            rv_cnt = -1;
          end
        end
        if (mem_req) begin
          gcnt++;
          if (gcnt >= gnt_dly) begin
            gcnt = 0;
            mem_gnt = 1'b1;
            check_eq("sram_op_expected", {31'd0, exp_ops.size() > 0}, 32'd1);
            if (exp_ops.size() > 0) begin
              op = exp_ops.pop_front();
              check_eq("sram_we", {31'd0, mem_we}, {31'd0, op.we});
              check_eq("sram_addr", {16'd0, mem_addr}, {16'd0, op.addr});
              if (op.we) check_eq("sram_wdata", {24'd0, mem_wdata}, {24'd0, op.wdata});
            end
            if (mem_we) begin
              sram[mem_addr] = mem_wdata;
            end else begin
              rv_data = sram[mem_addr];
              rv_cnt = rd_dly;
            end
          end
        end
      end
    end
  end

  // Edge counters and the bus_oe legality monitor.
  always @(negedge clk) begin
    if (bus_ack && !prev_ack) ack_cnt <= ack_cnt + 1;
    if (mem_req && !prev_mreq) memreq_rises <= memreq_rises + 1;
    prev_ack <= bus_ack;
    prev_mreq <= mem_req;
    if (bus_oe) check_eq("oe_only_in_read_data", {31'd0, tb_rd_phase}, 32'd1);
  end

  // One 4-phase byte: raise req, wait ack, hold a cycle, drop req, wait ack low.
  task automatic send_byte(input logic [7:0] b, output logic [7:0] obs_data, output logic obs_oe);
    bit seen;
    seen = 1'b0;
    bus_in = b;
    @(negedge clk);
    bus_req = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus_ack) seen = 1'b1;
    end
    check_eq("ack_rise", {31'd0, bus_ack}, 32'd1);
    obs_data = bus_out;
    obs_oe = bus_oe;
    @(negedge clk);
    check_eq("ack_held", {31'd0, bus_ack}, 32'd1);
    bus_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (!bus_ack) seen = 1'b1;
    end
    check_eq("ack_fall", {31'd0, bus_ack}, 32'd0);
    check_eq("oe_fall", {31'd0, bus_oe}, 32'd0);
  endtask

  // Wait (bounded) until every expected SRAM op has been granted.
  task automatic wait_sram_idle(input string tag);
    for (int i = 0; i < 60 && exp_ops.size() != 0; i++) @(negedge clk);
    check_eq(tag, exp_ops.size(), 32'd0);
  endtask

  // Read-data-phase byte: scoreboard compares bus_out/oe at ack.
  task automatic read_data_byte(input logic [7:0] exp_byte);
    logic [7:0] o;
    logic oe;
    logic [7:0] e;
    exp_rd.push_back(exp_byte);
    tb_rd_phase = 1'b1;
    send_byte(8'h00, o, oe);
    e = exp_rd.pop_front();
    check_eq("rd_data", {24'd0, o}, {24'd0, e});
    check_eq("rd_oe_at_ack", {31'd0, oe}, 32'd1);
    tb_rd_phase = 1'b0;
  endtask

  // Full transaction; data is write byte or expected read byte.
  task automatic txn(input bit is_rd, input logic [15:0] addr, input logic [7:0] data);
    logic [7:0] o;
    logic oe;
    bus_rd = is_rd;
    bus_wr = ~is_rd;
    exp_ops.push_back(sram_op_t'{we: ~is_rd, addr: addr, wdata: (is_rd ? 8'h00 : data)});
    send_byte(addr[7:0], o, oe);
    send_byte(addr[15:8], o, oe);
    if (is_rd) begin
      wait_sram_idle("prefetch_issued");
      read_data_byte(data);
    end else begin
      send_byte(data, o, oe);
      wait_sram_idle("write_done");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int m0;
    logic [7:0] o;
    logic oe;
    bit seen;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_ack", {31'd0, bus_ack}, 32'd0);
    check_eq("rst_oe", {31'd0, bus_oe}, 32'd0);
    check_eq("rst_bus_out", {24'd0, bus_out}, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check_eq("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check_eq("rst_proto_err", {31'd0, proto_err}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: write 0x1234 = 0xA5
    a0 = ack_cnt; m0 = memreq_rises;
    txn(1'b0, 16'h1234, 8'hA5);
    repeat (2) @(negedge clk);
    check_eq("t1_acks", ack_cnt - a0, 32'd3);
    check_eq("t1_memreq_once", memreq_rises - m0, 32'd1);
    check_eq("t1_sram", {24'd0, sram[16'h1234]}, 32'h0000_00A5);

    // 2: prefetched read of 0xBEEF
    a0 = ack_cnt;
    txn(1'b1, 16'hBEEF, 8'h5A);
    repeat (2) @(negedge clk);
    check_eq("t2_acks", ack_cnt - a0, 32'd3);

    // 3: back-to-back read / write / read-back, no idle flag gap
    a0 = ack_cnt; m0 = memreq_rises;
    txn(1'b1, 16'h0000, 8'h3C);
    txn(1'b0, 16'h0001, 8'h77);
    txn(1'b1, 16'h0001, 8'h77);
    repeat (2) @(negedge clk);
    check_eq("t3_acks", ack_cnt - a0, 32'd9);
    check_eq("t3_memreqs", memreq_rises - m0, 32'd3);
    bus_rd = 1'b0; bus_wr = 1'b0;
    repeat (6) @(negedge clk);

    // 4: abort after addr lo, then a normal write
    m0 = memreq_rises;
    bus_rd = 1'b1;
    send_byte(8'h10, o, oe);
    bus_rd = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("t4_no_memreq", memreq_rises - m0, 32'd0);
    a0 = ack_cnt;
    txn(1'b0, 16'h0010, 8'h01);
    repeat (2) @(negedge clk);
    check_eq("t4_acks", ack_cnt - a0, 32'd3);
    check_eq("t4_sram", {24'd0, sram[16'h0010]}, 32'd1);
    bus_wr = 1'b0;
    repeat (6) @(negedge clk);

    // 5a: reset while a read is waiting in RD_MEM with data req raised
    gnt_dly = 50;
    bus_rd = 1'b1;
    send_byte(8'h00, o, oe);
    send_byte(8'h20, o, oe);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    check_eq("t5_memreq_up", {31'd0, mem_req}, 32'd1);
    bus_req = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_ack", {31'd0, bus_ack}, 32'd0);
    check_eq("t5_rst_oe", {31'd0, bus_oe}, 32'd0);
    check_eq("t5_rst_memreq", {31'd0, mem_req}, 32'd0);
    bus_req = 1'b0; bus_rd = 1'b0;
    exp_ops.delete();
    gnt_dly = 2;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 5b: reset while oe=1 and ack=1 (req still high)
    bus_rd = 1'b1;
    exp_ops.push_back(sram_op_t'{we: 1'b0, addr: 16'hBEEF, wdata: 8'h00});
    send_byte(8'hEF, o, oe);
    send_byte(8'hBE, o, oe);
    wait_sram_idle("t5b_prefetch");
    tb_rd_phase = 1'b1;
    @(negedge clk);
    bus_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus_ack) seen = 1'b1;
    end
    check_eq("t5b_oe_before_rst", {31'd0, bus_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5b_rst_ack", {31'd0, bus_ack}, 32'd0);
    check_eq("t5b_rst_oe", {31'd0, bus_oe}, 32'd0);
    check_eq("t5b_rst_bus_out", {24'd0, bus_out}, 32'd0);
    bus_req = 1'b0; bus_rd = 1'b0;
    tb_rd_phase = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    txn(1'b1, 16'hBEEF, 8'h5A);
    bus_rd = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("t6_pre_proto_err", {31'd0, proto_err}, 32'd0);

    // 6: rd and wr both high from addr hi onward
    bus_rd = 1'b1; bus_wr = 1'b0;
    exp_ops.push_back(sram_op_t'{we: 1'b0, addr: 16'h0040, wdata: 8'h00});
    send_byte(8'h40, o, oe);
    bus_wr = 1'b1;
    send_byte(8'h00, o, oe);
    wait_sram_idle("t6_read_issued");
    read_data_byte(8'h99);
    check_eq("t6_proto_err", {31'd0, proto_err}, 32'd1);
    bus_rd = 1'b0; bus_wr = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("t6_proto_err_sticky", {31'd0, proto_err}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_proto_err_rst", {31'd0, proto_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("end_no_pending_ops", exp_ops.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
